// File: rtl/approx_adder_error_monitor16.sv
// Error-characterisation monitor for 16-bit approximate adders: recomputes the exact sum
// per accepted sample and accumulates error count, saturating error-distance sum and max.
module approx_adder_error_monitor16 #(
    parameter int WIDTH       = 16,
    parameter int NUM_SAMPLES = 256,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     add1_i,
    input  logic [WIDTH-1:0]     add2_i,
    input  logic [WIDTH:0]       approx_result_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [15:0]          err_count_o,
    output logic [ACC_WIDTH-1:0] sum_ed_o,
    output logic [WIDTH:0]       max_ed_o,
    output logic [15:0]          sample_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 clear_stats;
    logic                 accept_p0;
    logic                 last_p0;

    logic                 vld_p1_q;
    logic [WIDTH:0]       exact_p1_q;
    logic [WIDTH:0]       approx_p1_q;
    logic [WIDTH:0]       ed_p2;

    logic [15:0]          err_count_q;
    logic [ACC_WIDTH-1:0] sum_ed_q;
    logic [WIDTH:0]       max_ed_q;
    logic [15:0]          sample_count_q;

    // Unsigned magnitude of the difference; never wraps through a sign bit.
    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sat_add_acc(input logic [ACC_WIDTH-1:0] acc,
                                                         input logic [WIDTH:0]       ed);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, acc} + (ACC_WIDTH+1)'(ed);
        return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept_p0 = (state_q == S_RUN) && valid_i;
    assign last_p0   = accept_p0 && (sample_count_q == 16'(NUM_SAMPLES - 1));

    always_comb begin
        state_d     = state_q;
        clear_stats = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_RUN;
                    clear_stats = 1'b1;
                end
            end
            S_RUN: begin
                if (last_p0) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (start_i) begin
                    state_d     = S_RUN;
                    clear_stats = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            vld_p1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_p1_q <= accept_p0;
        end
    end

    // ---- stage 1: capture exact sum and approximate result on accept ----
    always_ff @(posedge clk_i) begin
        if (accept_p0) begin
            exact_p1_q  <= {1'b0, add1_i} + {1'b0, add2_i};
            approx_p1_q <= approx_result_i;
        end
    end

    // ---- stage 2: error distance folded into the run statistics ----
    assign ed_p2 = abs_diff(approx_p1_q, exact_p1_q);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_stats) begin
            err_count_q    <= '0;
            sum_ed_q       <= '0;
            max_ed_q       <= '0;
            sample_count_q <= '0;
        end else begin
            if (accept_p0) sample_count_q <= sample_count_q + 16'd1;
            if (vld_p1_q) begin
                sum_ed_q <= sat_add_acc(sum_ed_q, ed_p2);
                if (ed_p2 != '0)      err_count_q <= sat_inc16(err_count_q);
                if (ed_p2 > max_ed_q) max_ed_q    <= ed_p2;
            end
        end
    end

    assign ready_o        = (state_q == S_RUN);
    assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o         = (state_q == S_DONE);
    assign err_count_o    = err_count_q;
    assign sum_ed_o       = sum_ed_q;
    assign max_ed_o       = max_ed_q;
    assign sample_count_o = sample_count_q;

endmodule

// File: doc/approx_adder_error_monitor16.md
Name: approx_adder_error_monitor16

Overview:
- Sequential error-characterisation stage directly downstream of the 16-bit approximate ripple-carry adders.
- Captures each operand pair together with the approximate 17-bit result the adder produced, and recomputes the exact sum internally.
- Over a run of NUM_SAMPLES accepted samples it accumulates:
  - error count (samples where approximate differs from exact),
  - sum of absolute error distance,
  - maximum error distance.
- Feeds the MED/ER/max-error figures for every approximate adder variant in the library.

Parameters:
- width, 16: operand width; the result and exact sum are width+1 bits.
- NUM_SAMPLES, 256: samples per run; legal range 1..65535.
- ACC_WIDTH, 32: width of the error-distance accumulator; must be at least width+1.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  starts a run; honoured in IDLE and DONE only.
- valid_i  input  1  sample on add1_i/add2_i/approx_result_i is valid.
- ready_o  output  1  monitor accepts a sample this cycle.
- add1_i  input  width  operand A as presented to the adder.
- add2_i  input  width  operand B as presented to the adder.
- approx_result_i  input  width+1  approximate adder output, {carry, sum}.
- busy_o  output  1  high in RUN and DRAIN.
- done_o  output  1  high in DONE (level, not pulse).
- err_count_o  output  16  samples with nonzero error distance.
- sum_ed_o  output  ACC_WIDTH  saturating sum of |approx - exact|.
- max_ed_o  output  width+1  largest |approx - exact| seen in the run.
- sample_count_o  output  16  samples accepted so far in this run.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous, active-high. While rst_i is high at an edge:
  - state goes to IDLE;
  - all accumulators, counters and pipeline valid bits clear;
  - ready_o, busy_o and done_o are 0.
  - Reset mid-run discards the partial run entirely.
- States:
  - IDLE: ready_o=0. start_i=1 clears err_count, sum_ed, max_ed and sample_count, then moves to RUN.
  - RUN: ready_o=1. A sample is accepted on an edge where valid_i && ready_o. An accept that brings sample_count to NUM_SAMPLES moves to DRAIN. start_i is ignored.
  - DRAIN: ready_o=0 for exactly one cycle, then DONE.
  - DONE: done_o=1, outputs frozen. start_i=1 clears the statistics and re-enters RUN on the next edge (done_o falls on that edge). Otherwise DONE holds indefinitely.
- Handshake: ready_o depends only on state, never on valid_i. valid_i while ready_o=0 is ignored (no buffering, no back-pressure beyond ready_o).
- Pipeline:
  - Stage 1, on the accept edge: registers exact = add1_i + add2_i (width+1 bits, zero-extended), registers approx_result_i, sets s1_valid.
  - Stage 2, on the next edge, when s1_valid: ed = |approx - exact|, computed as a width+1-bit unsigned magnitude (compare, then subtract larger minus smaller; no sign wrap). Then:
    - sum_ed += ed, saturating at 2^ACC_WIDTH-1 and holding there;
    - err_count += (ed != 0), saturating at 0xFFFF;
    - max_ed = max(max_ed, ed).
- Latency and counters:
  - A sample accepted at edge k is visible in the accumulators after edge k+1.
  - sample_count_o increments at the accept edge.
  - The last sample accepted at edge k means DRAIN is occupied after edge k, and DONE with final values after edge k+1.
- Back-to-back accepts every cycle are supported at full rate; the stage-1 register is overwritten each cycle while stage 2 consumes it.
- NUM_SAMPLES=1: the first accept goes RUN->DRAIN directly.
- Output reset values: every output is 0.

Test Plan:
- Exact samples: reset, start; then 4 samples (0x0003, 0x0005, 0x00008), (0xFFFF, 0x0001, 0x10000), (0x1234, 0x0000, 0x01234), (0x8000, 0x8000, 0x10000) with NUM_SAMPLES=4 -> done_o after 5 edges of RUN/DRAIN; err_count_o=0, sum_ed_o=0, max_ed_o=0, sample_count_o=4.
- Signed-magnitude check: (0x0003, 0x0005, approx 0x00009) and (0x0010, 0x0010, approx 0x0001D) -> ed 1 and 3; err_count_o=2, sum_ed_o=4, max_ed_o=3.
- Handshake gaps: valid_i toggled 1,0,1,0 during RUN -> only valid cycles counted; valid_i held high in DONE -> sample_count_o stays at NUM_SAMPLES; ready_o=0 in IDLE, DRAIN and DONE.
- Saturation: ACC_WIDTH=17; feed samples with ed=0x1FFFF twice -> sum_ed_o=0x1FFFF (held), max_ed_o=0x1FFFF.
- Reset mid-run: rst_i asserted after 2 of 4 samples -> next cycle is IDLE with all outputs 0; a fresh start gives counts from zero.
- Restart from DONE: start_i in DONE -> done_o drops next edge, stats cleared, new run of NUM_SAMPLES completes with independent results.
